// File: rtl/acc_pkg.sv
// Shared types for the accelerator response adapter: the buffered response entry,
// the per-beat writeback view and the writeback FSM state encoding.
// Response fields are sized for the widest supported configuration (data up to
// 64 bits, ID up to 8 bits); narrower instances zero-extend on entry.
package acc_pkg;

    localparam int unsigned AccMaxDataWidth = 64;
    localparam int unsigned AccMaxIdWidth   = 8;

    typedef enum logic [1:0] {
        IDLE,
        WB0,
        WB1
    } acc_wb_state_e;

    typedef struct packed {
        logic [AccMaxIdWidth-1:0]   id;
        logic [4:0]                 rd;
        logic [AccMaxDataWidth-1:0] data0;
        logic [AccMaxDataWidth-1:0] data1;
        logic                       dualwb;
        logic                       error;
    } acc_rsp_t;

    typedef struct packed {
        logic [4:0]                 rd;
        logic [AccMaxDataWidth-1:0] data;
        logic                       error;
        logic                       last;
    } acc_beat_t;

    // First beat of a response; an errored response is always a single beat.
    function automatic acc_beat_t acc_first_beat(acc_rsp_t rsp, logic dual_en);
        acc_beat_t beat;
        beat.rd    = rsp.rd;
        beat.data  = rsp.data0;
        beat.error = rsp.error;
        beat.last  = !(dual_en && rsp.dualwb && !rsp.error);
        return beat;
    endfunction

    // Second beat of a dual response; rd wraps 31 -> 0 through 5-bit arithmetic.
    function automatic acc_beat_t acc_second_beat(acc_rsp_t rsp);
        acc_beat_t beat;
        beat.rd    = rsp.rd + 5'd1;
        beat.data  = rsp.data1;
        beat.error = 1'b0;
        beat.last  = 1'b1;
        return beat;
    endfunction

endpackage

// File: rtl/acc_rsp_fifo.sv
// In-order response buffer with registered full flag and no fall-through.
// Exposes the head entry and the one behind it so the consumer can preload the
// next head in the same cycle it pops. The user never pushes when full nor pops
// when empty.
module acc_rsp_fifo #(
    parameter type         T     = logic,
    parameter int unsigned Depth = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push_i,
    input  T                           data_i,
    input  logic                       pop_i,
    output T                           head_o,
    output T                           second_o,
    output logic [$clog2(Depth+1)-1:0] count_o,
    output logic                       full_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);

    T                  mem_q [Depth];
    logic [PtrW-1:0]   wr_ptr_q;
    logic [PtrW-1:0]   rd_ptr_q;
    logic [CntW-1:0]   count_q;
    logic [CntW-1:0]   count_d;
    logic              full_q;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
        return (ptr == PtrW'(Depth - 1)) ? '0 : ptr + 1'b1;
    endfunction

    // Occupancy after this edge; push and pop together leave it unchanged.
    always_comb begin
        count_d = count_q + CntW'(push_i) - CntW'(pop_i);
    end

    // Entry storage, written only on push; contents are don't-care when unoccupied.
    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    // Pointers, count and full flag with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
        end else begin
            if (push_i) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (pop_i) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            count_q <= count_d;
            full_q  <= (count_d == CntW'(Depth));
        end
    end

    assign head_o   = mem_q[rd_ptr_q];
    assign second_o = mem_q[ptr_inc(rd_ptr_q)];
    assign count_o  = count_q;
    assign full_o   = full_q;

endmodule

// File: rtl/acc_adapter_rsp.sv
// Accelerator response adapter: buffers interconnect responses in arrival order and
// replays each as one or two register-writeback beats toward the core.
// Build option: define ACC_ADAPTER_DUALWB_EN to enable two-register writeback;
// without it p_dualwb_i/p_data1_i are ignored and every response is a single beat.
// DataWidth must not exceed 64 and IdWidth must not exceed 8.
module acc_adapter_rsp
    import acc_pkg::*;
#(
    parameter int unsigned DataWidth = 32,
    parameter int unsigned IdWidth   = 1,
    parameter int unsigned FifoDepth = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 p_valid_i,
    output logic                 p_ready_o,
    input  logic [IdWidth-1:0]   p_id_i,
    input  logic [4:0]           p_rd_i,
    input  logic [DataWidth-1:0] p_data0_i,
    input  logic [DataWidth-1:0] p_data1_i,
    input  logic                 p_dualwb_i,
    input  logic                 p_error_i,
    output logic                 wb_valid_o,
    input  logic                 wb_ready_i,
    output logic [4:0]           wb_rd_o,
    output logic [DataWidth-1:0] wb_data_o,
    output logic                 wb_error_o,
    output logic                 wb_last_o
);

    localparam int unsigned CntW = $clog2(FifoDepth + 1);

`ifdef ACC_ADAPTER_DUALWB_EN
    localparam logic DualEn = 1'b1;
`else
    localparam logic DualEn = 1'b0;
`endif

    acc_rsp_t        push_rsp;
    acc_rsp_t        head;
    acc_rsp_t        second;
    acc_rsp_t        nxt;
    acc_beat_t       refill_beat;
    logic [CntW-1:0] count;
    logic [CntW-1:0] count_after;
    logic            full;
    logic            push;
    logic            pop;
    logic            avail_after;

    acc_wb_state_e   state_q;
    acc_beat_t       beat_q;
    logic            valid_q;

    assign p_ready_o = !full;
    assign push      = p_valid_i && !full;
    // An entry stays buffered until its last beat is taken.
    assign pop       = valid_q && wb_ready_i && beat_q.last;

    // Widen the incoming response into a buffer entry.
    always_comb begin
        push_rsp       = '0;
        push_rsp.id    = AccMaxIdWidth'(p_id_i);
        push_rsp.rd    = p_rd_i;
        push_rsp.data0 = AccMaxDataWidth'(p_data0_i);
        push_rsp.error = p_error_i;
`ifdef ACC_ADAPTER_DUALWB_EN
        push_rsp.data1  = AccMaxDataWidth'(p_data1_i);
        push_rsp.dualwb = p_dualwb_i;
`endif
    end

`ifndef ACC_ADAPTER_DUALWB_EN
    logic unused_dual_in;
    assign unused_dual_in = ^{p_data1_i, p_dualwb_i};
`endif

    acc_rsp_fifo #(
        .T     (acc_rsp_t),
        .Depth (FifoDepth)
    ) u_fifo (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .push_i   (push),
        .data_i   (push_rsp),
        .pop_i    (pop),
        .head_o   (head),
        .second_o (second),
        .count_o  (count),
        .full_o   (full)
    );

    // Entry that will sit at the FIFO head after this edge; lets the FSM load the
    // next beat without an idle bubble and gives 1-cycle push-to-valid latency.
    always_comb begin
        count_after = count - CntW'(pop) + CntW'(push);
        avail_after = (count_after != '0);
        if (pop) begin
            nxt = (count > CntW'(1)) ? second : push_rsp;
        end else begin
            nxt = (count != '0) ? head : push_rsp;
        end
        refill_beat = acc_first_beat(nxt, DualEn);
    end

    // Writeback FSM with registered beat outputs; outputs only move when idle or
    // when the current beat is taken, so they hold under backpressure.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            beat_q  <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (avail_after) begin
                        state_q <= WB0;
                        valid_q <= 1'b1;
                        beat_q  <= refill_beat;
                    end
                end
                WB0: begin
                    if (wb_ready_i) begin
                        if (!beat_q.last) begin
`ifdef ACC_ADAPTER_DUALWB_EN
                            state_q <= WB1;
                            beat_q  <= acc_second_beat(head);
`endif
                        end else if (avail_after) begin
                            beat_q <= refill_beat;
                        end else begin
                            state_q <= IDLE;
                            valid_q <= 1'b0;
                            beat_q  <= '0;
                        end
                    end
                end
`ifdef ACC_ADAPTER_DUALWB_EN
                WB1: begin
                    if (wb_ready_i) begin
                        if (avail_after) begin
                            state_q <= WB0;
                            beat_q  <= refill_beat;
                        end else begin
                            state_q <= IDLE;
                            valid_q <= 1'b0;
                            beat_q  <= '0;
                        end
                    end
                end
`endif
                default: begin
                    state_q <= IDLE;
                    valid_q <= 1'b0;
                    beat_q  <= '0;
                end
            endcase
        end
    end

    assign wb_valid_o = valid_q;
    assign wb_rd_o    = beat_q.rd;
    assign wb_data_o  = beat_q.data[DataWidth-1:0];
    assign wb_error_o = beat_q.error;
    assign wb_last_o  = beat_q.last;

    // ID is debug-only and upper data bits are padding in narrow builds.
    logic unused_fields;
    assign unused_fields = ^{head, second, beat_q.data};

endmodule

// File: doc/acc_adapter_rsp.md
ACC_ADAPTER_RSP -- requirements
Module: acc_adapter_rsp

Interface
REQ-001 SHALL have parameter DataWidth, default 32: width of each response data word.
REQ-002 SHALL have parameter IdWidth, default 1: width of the interconnect response ID.
REQ-003 SHALL have parameter FifoDepth, default 2: response buffer entries; legal range 1..8.
REQ-004 SHALL have port clk_i, input, 1: single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_i, input, 1: reset, synchronous and active-high.
REQ-006 SHALL have ports for the interconnect-side response:
- p_valid_i, input, 1: response valid.
- p_ready_o, output, 1: response accepted.
- p_id_i, input, IdWidth: response ID.
- p_rd_i, input, 5: destination register.
- p_data0_i, input, DataWidth: first writeback word.
- p_data1_i, input, DataWidth: second writeback word.
- p_dualwb_i, input, 1: two-register writeback.
- p_error_i, input, 1: accelerator error.
REQ-007 SHALL have ports for the core-side writeback:
- wb_valid_o, output, 1: writeback valid.
- wb_ready_i, input, 1: core accepts the writeback.
- wb_rd_o, output, 5: register index.
- wb_data_o, output, DataWidth: write data.
- wb_error_o, output, 1: error flag.
- wb_last_o, output, 1: final beat of the response.

Function
REQ-008 SHALL accept a response when p_valid_i && p_ready_o on a rising edge.
REQ-009 SHALL drive p_ready_o = !full, where full is registered state. A pop in the same cycle SHALL NOT raise p_ready_o.
REQ-010 SHALL store accepted responses in order in a FifoDepth-entry FIFO. The FIFO SHALL be registered, with no fall-through: minimum latency from p-handshake to wb_valid_o is 1 cycle.
REQ-011 SHALL be controlled by an FSM with three states:
- IDLE: FIFO empty; wb_valid_o = 0.
- WB0: head entry, first beat. wb_rd_o = rd; wb_data_o = data0.
- WB1: second beat. wb_rd_o = (rd+1) mod 32; wb_data_o = data1.
REQ-012 SHALL make the following FSM transitions:
- IDLE -> WB0 when the FIFO is non-empty.
- WB0 with wb_ready_i and a single-beat response: pop the entry, then go to WB0 if further entries remain, else IDLE.
- WB0 with wb_ready_i and dualwb && !error: go to WB1.
- WB1 with wb_ready_i: pop the entry, then go to WB0 if further entries remain, else IDLE.
REQ-013 SHALL assert wb_last_o in WB0 for single-beat responses and in WB1 for dual responses.
REQ-014 SHALL hold wb_valid_o and all wb_* outputs stable while wb_valid_o && !wb_ready_i.
REQ-015 SHALL deliver an errored response as one beat with wb_error_o = 1, wb_data_o = data0 and wb_last_o = 1, ignoring dualwb.
REQ-016 SHALL wrap rd 31 to rd+1 = 0 on the second beat; no suppression.
REQ-017 SHALL NOT use p_id_i for reordering; it is stored for debug only. Responses leave in arrival order.
REQ-018 SHALL allow a push and a pop in the same cycle when the FIFO is neither empty nor full; occupancy is then unchanged.

Reset
REQ-019 SHALL, on rst_i high at a rising edge, move the FSM to IDLE, clear FIFO pointers and count, and discard any in-flight beat, including mid-WB1.
REQ-020 SHALL drive the following values during and after reset: wb_valid_o = 0, wb_last_o = 0, wb_error_o = 0, wb_rd_o = 0, wb_data_o = 0, p_ready_o = 1 from the first cycle after reset.

Configuration
REQ-021 SHALL use macro ACC_ADAPTER_DUALWB_EN:
- Defined: dual writeback SHALL be supported as in REQ-011 to REQ-016.
- Undefined: the WB1 state and data1 storage SHALL be removed, p_dualwb_i and p_data1_i SHALL be ignored, and every response SHALL be single-beat with wb_last_o = 1.

Structure
REQ-022 SHALL take the following from acc_pkg:
- acc_rsp_t: a struct of id, rd, data0, data1, dualwb, error.
- acc_wb_state_e: an enum with values IDLE, WB0, WB1.
REQ-023 SHALL place the FIFO in one sub-module, acc_rsp_fifo, parameterised by entry type and depth, with synchronous active-high reset.

Verification
REQ-024 The bench SHALL apply a single response rd=5, data0=0xDEADBEEF, dualwb=0, with wb_ready_i=1. Required: one beat one cycle later, with wb_rd_o=5, wb_data_o=0xDEADBEEF and wb_last_o=1.
REQ-025 The bench SHALL apply a dual response rd=31, data0=0x1, data1=0x2. Required: beat rd=31, data=0x1, last=0, then beat rd=0, data=0x2, last=1.
REQ-026 The bench SHALL hold wb_ready_i=0 and push FifoDepth=2 responses. Required: p_ready_o=0 after the second accept; no third accept until the first beat is accepted.
REQ-027 The bench SHALL apply an error response with dualwb=1, data0=0xBAD. Required: a single beat with wb_error_o=1, wb_data_o=0xBAD and wb_last_o=1.
REQ-028 The bench SHALL assert rst_i in WB1 with wb_ready_i=0. Required: wb_valid_o=0 the next cycle, the FIFO empty, and p_ready_o=1.
REQ-029 The bench SHALL run with ACC_ADAPTER_DUALWB_EN undefined and apply a dual response rd=3, data0=0xA, data1=0xB. Required: a single beat with rd=3, data=0xA and last=1.
